writeback: RTL and testbench

Writeback stage of the processor pipeline, the write side of the register file that the decode stage reads. It accepts results from execute/memory over a valid/ready handshake and buffers them in a small in-order FIFO. It commits one result per cycle into a 32x32 register array and provides decode with two combinational read ports, including forwarding and per-register pending (busy) tracking.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/writeback.sv | 136 +++++++++++++
 tb/tb_writeback.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the writeback slice.
//   XLEN       : register and result data width
//   NREG       : number of architectural registers
//   REG_AW     : register address width
//   RESET_BASE : register i resets to RESET_BASE + i
//   wb_entry_t : one buffered result {dst, data}
package pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned RESET_BASE = 10;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] reg_reset_value(input int unsigned idx);
    return XLEN'(RESET_BASE + idx);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer for the writeback stage, built as a shift FIFO so
// entries[0] is always the oldest (head) and higher indices are younger.
//   clk, rst_n  : clock, synchronous active-low reset (empties the buffer)
//   push, push_entry : append an entry at the tail
//   pop         : drop the head entry
//   count       : number of valid entries
//   head        : oldest entry (entries[0])
//   entries     : all slots, oldest first; only the first 'count' are valid
module wb_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output logic [CntW-1:0] count,
  output wb_entry_t       head,
  output wb_entry_t       entries [Depth]
);

  wb_entry_t       mem_q [Depth];
  wb_entry_t       mem_d [Depth];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop_ok, push_ok;

  assign pop_ok  = pop && (cnt_q != '0);
  // A full buffer can still take a push when the head leaves the same cycle.
  assign push_ok = push && ((cnt_q != CntW'(Depth)) || pop_ok);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_ok) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d = cnt_q - CntW'(1);
    end
    if (push_ok) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (CntW'(i) == cnt_d) begin
          mem_d[i] = push_entry;
        end
      end
      cnt_d = cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign count   = cnt_q;
  assign head    = mem_q[0];
  assign entries = mem_q;

endmodule

// File: rtl/writeback.sv
// Writeback stage: buffers results from execute/memory, commits one per cycle
// into the register array and serves decode's two read ports with forwarding
// from the buffer plus per-register pending-writer tracking.
//   clk, rst_n          : clock, synchronous active-low reset
//   res_valid/res_ready : result handshake; res_ready = buffer not full
//   res_wen, res_dst, res_data : result payload (res_wen=0 drops it)
//   wb_stall            : hold the commit this cycle
//   iss_valid, iss_dst, iss_ready : decode announces a future writer of iss_dst
//   rd_addrN, rd_dataN, rd_busyN  : combinational read ports
module writeback
  import pipe_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_wen,
  input  logic [REG_AW-1:0] res_dst,
  input  logic [XLEN-1:0]   res_data,
  input  logic              wb_stall,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_dst,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [XLEN-1:0]   rd_data1,
  output logic [XLEN-1:0]   rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [CntW-1:0] fifo_count;
  wb_entry_t       fifo_head;
  wb_entry_t       fifo_entries [FIFO_DEPTH];
  wb_entry_t       push_entry;
  logic            accept, push, commit, issue;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [1:0]        pend_q [NREG];
  logic [1:0]        pend_d [NREG];
  logic [REG_AW-1:0] rd_addr [2];
  logic [XLEN-1:0]   rd_data [2];

  // res_ready looks only at the registered count, never at wb_stall.
  assign res_ready  = (fifo_count != CntW'(FIFO_DEPTH));
  assign accept     = res_valid && res_ready;
  assign push       = accept && res_wen;
  assign commit     = (fifo_count != '0) && !wb_stall;
  assign push_entry = '{dst: res_dst, data: res_data};

  wb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (commit),
    .count      (fifo_count),
    .head       (fifo_head),
    .entries    (fifo_entries)
  );

  // Register array
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= reg_reset_value(i);
      end
    end else if (commit) begin
      regs_q[fifo_head.dst] <= fifo_head.data;
    end
  end

  // Read ports: array value, overridden by buffered entries oldest to youngest
  // so the youngest matching entry wins.
  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if ((CntW'(i) < fifo_count) && (fifo_entries[i].dst == rd_addr[p])) begin
          rd_data[p] = fifo_entries[i].data;
        end
      end
    end
  end

  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];

  // Pending counters: the writer stops being pending once its result is
  // buffered, since forwarding makes it visible from then on.
  assign iss_ready = (pend_q[iss_dst] != 2'd3);
  assign issue     = iss_valid && iss_ready;

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      logic inc, dec;
      inc       = issue && (iss_dst == REG_AW'(r));
      dec       = push && (res_dst == REG_AW'(r));
      pend_d[r] = pend_q[r];
      if (inc && !dec) begin
        pend_d[r] = pend_q[r] + 2'd1;
      end else if (dec && !inc && (pend_q[r] != 2'd0)) begin
        pend_d[r] = pend_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rd_busy1 = (pend_q[rd_addr1] != 2'd0);
  assign rd_busy2 = (pend_q[rd_addr2] != 2'd0);

  // A result for a register with no pending writer is a protocol error.
  logic pend_underflow;
  assign pend_underflow = push && (pend_q[res_dst] == 2'd0) &&
                          !(issue && (iss_dst == res_dst));

  a_no_pend_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !pend_underflow);

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              res_valid, res_ready, res_wen;
  logic [REG_AW-1:0] res_dst;
  logic [XLEN-1:0]   res_data;
  logic              wb_stall;
  logic              iss_valid, iss_ready;
  logic [REG_AW-1:0] iss_dst;
  logic [REG_AW-1:0] rd_addr1, rd_addr2;
  logic [XLEN-1:0]   rd_data1, rd_data2;
  logic              rd_busy1, rd_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        rr;
    logic        ir;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  writeback #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_wen   (res_wen),
    .res_dst   (res_dst),
    .res_data  (res_data),
    .wb_stall  (wb_stall),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .rd_busy1  (rd_busy1),
    .rd_busy2  (rd_busy2)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Monitor: checks the outputs of the current cycle away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({e.name, ".rd_data1"}, rd_data1, e.d1);
      cmp({e.name, ".rd_busy1"}, {31'd0, rd_busy1}, {31'd0, e.b1});
      cmp({e.name, ".rd_data2"}, rd_data2, e.d2);
      cmp({e.name, ".rd_busy2"}, {31'd0, rd_busy2}, {31'd0, e.b2});
      cmp({e.name, ".res_ready"}, {31'd0, res_ready}, {31'd0, e.rr});
      cmp({e.name, ".iss_ready"}, {31'd0, iss_ready}, {31'd0, e.ir});
    end
  end

  task automatic expect_out(input string nm, input logic [31:0] d1, input logic b1,
                            input logic [31:0] d2, input logic b2,
                            input logic rr, input logic ir);
    exp_t e;
    e.name = nm; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.rr = rr; e.ir = ir;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] dst, input logic [31:0] data);
    res_valid = 1'b1; res_wen = 1'b1; res_dst = dst; res_data = data;
  endtask

  task automatic idle_res();
    res_valid = 1'b0; res_wen = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_wen = 1'b0; res_dst = '0; res_data = '0;
    wb_stall = 1'b0; iss_valid = 1'b0; iss_dst = '0; rd_addr1 = '0; rd_addr2 = 5'd31;
    step();
    step();
    rst_n = 1'b1;

    // Reset values
    expect_out("reset", 32'd10, 0, 32'd41, 0, 1, 1);
    step();

    // Single writer to r5
    rd_addr1 = 5'd5;
    iss_valid = 1'b1; iss_dst = 5'd5;
    expect_out("r5_issue", 32'd15, 0, 32'd41, 0, 1, 1);
    step();
    iss_valid = 1'b0;
    offer(5'd5, 32'hDEAD_BEEF);
    expect_out("r5_busy", 32'd15, 1, 32'd41, 0, 1, 1);
    step();
    idle_res();
    expect_out("r5_fwd", 32'hDEAD_BEEF, 0, 32'd41, 0, 1, 1);
    step();
    expect_out("r5_array", 32'hDEAD_BEEF, 0, 32'd41, 0, 1, 1);
    step();

    // Two writers to r3 under stall
    rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    iss_valid = 1'b1; iss_dst = 5'd3;
    step();
    step();
    iss_valid = 1'b0;
    wb_stall = 1'b1;
    offer(5'd3, 32'd1);
    expect_out("r3_acc1", 32'd13, 1, 32'd10, 0, 1, 1);
    step();
    offer(5'd3, 32'd2);
    expect_out("r3_acc2", 32'd1, 1, 32'd10, 0, 1, 1);
    step();
    idle_res();
    expect_out("r3_full", 32'd2, 0, 32'd10, 0, 0, 1);
    step();
    expect_out("r3_full_hold", 32'd2, 0, 32'd10, 0, 0, 1);
    step();
    wb_stall = 1'b0;
    expect_out("r3_release", 32'd2, 0, 32'd10, 0, 0, 1);
    step();
    expect_out("r3_pop1", 32'd2, 0, 32'd10, 0, 1, 1);
    step();
    expect_out("r3_pop2", 32'd2, 0, 32'd10, 0, 1, 1);
    step();

    // Dropped result (res_wen=0)
    rd_addr1 = 5'd7; rd_addr2 = 5'd31;
    res_valid = 1'b1; res_wen = 1'b0; res_dst = 5'd7; res_data = 32'h55;
    expect_out("r7_drop", 32'd17, 0, 32'd41, 0, 1, 1);
    step();
    idle_res();
    expect_out("r7_after", 32'd17, 0, 32'd41, 0, 1, 1);
    step();
    expect_out("r7_after2", 32'd17, 0, 32'd41, 0, 1, 1);
    step();

    // Pending counter saturation on r9
    rd_addr1 = 5'd9; rd_addr2 = 5'd5;
    iss_valid = 1'b1; iss_dst = 5'd9;
    expect_out("r9_iss1", 32'd19, 0, 32'hDEAD_BEEF, 0, 1, 1);
    step();
    expect_out("r9_iss2", 32'd19, 1, 32'hDEAD_BEEF, 0, 1, 1);
    step();
    expect_out("r9_iss3", 32'd19, 1, 32'hDEAD_BEEF, 0, 1, 1);
    step();
    // Counter at 3: issue blocked, accept still decrements to 2.
    offer(5'd9, 32'h900);
    expect_out("r9_sat", 32'd19, 1, 32'hDEAD_BEEF, 0, 1, 0);
    step();
    // Counter at 2: issue and accept together leave it at 2.
    offer(5'd9, 32'h901);
    expect_out("r9_both", 32'h900, 1, 32'hDEAD_BEEF, 0, 1, 1);
    step();
    idle_res();
    expect_out("r9_held", 32'h901, 1, 32'hDEAD_BEEF, 0, 1, 1);
    step();
    iss_valid = 1'b0;
    expect_out("r9_sat_again", 32'h901, 1, 32'hDEAD_BEEF, 0, 1, 0);
    step();

    // Reset with a full buffer
    rd_addr1 = 5'd4; rd_addr2 = 5'd9;
    iss_valid = 1'b1; iss_dst = 5'd4;
    step();
    step();
    iss_valid = 1'b0;
    wb_stall = 1'b1;
    offer(5'd4, 32'h40);
    expect_out("r4_acc1", 32'd14, 1, 32'h901, 1, 1, 1);
    step();
    offer(5'd4, 32'h41);
    expect_out("r4_acc2", 32'h40, 1, 32'h901, 1, 1, 1);
    step();
    idle_res();
    expect_out("r4_full", 32'h41, 0, 32'h901, 1, 0, 1);
    step();
    // Traffic during the reset cycle must be ignored.
    rst_n = 1'b0;
    iss_valid = 1'b1;
    offer(5'd4, 32'h99);
    step();
    rst_n = 1'b1;
    iss_valid = 1'b0;
    idle_res();
    wb_stall = 1'b0;
    expect_out("rst_clear", 32'd14, 0, 32'd19, 0, 1, 1);
    step();
    expect_out("rst_no_commit", 32'd14, 0, 32'd19, 0, 1, 1);
    step();
    step();
    expect_out("rst_no_commit2", 32'd14, 0, 32'd19, 0, 1, 1);
    step();
    step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
